// File: rtl/delay_align_ctrl.sv
// Delay-alignment controller: sweeps the delay select, correlates ref_sig against
// dly_sig over 2^LOG2_N samples per setting, then programs the best-scoring setting.
module delay_align_ctrl #(
    parameter int unsigned MAX_DELAY      = 10,
    parameter int unsigned SETTLE_SAMPLES = 2,
    parameter int unsigned LOG2_N         = 4
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   sam_clk_en,
    input  logic                   start,
    input  logic [17:0]            ref_sig,
    input  logic [17:0]            dly_sig,
    output logic [3:0]             delay_change,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             best_delay,
    output logic [36+LOG2_N-1:0]   best_metric
);

    localparam int unsigned       ACC_W       = 36 + LOG2_N;
    localparam logic [3:0]        LAST_DELAY  = 4'(MAX_DELAY);
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);
    localparam logic [LOG2_N-1:0] SAMPLE_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_COMPARE,
        S_FINISH
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          delay_q, delay_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [3:0]          best_delay_q, best_delay_d;
    logic [ACC_W-1:0]    best_metric_q, best_metric_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [7:0]          settle_cnt_q, settle_cnt_d;
    logic [LOG2_N-1:0]   sample_cnt_q, sample_cnt_d;
    logic signed [35:0]  product;

    always_comb begin
        product       = $signed(ref_sig) * $signed(dly_sig);
        state_d       = state_q;
        delay_d       = delay_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        best_delay_d  = best_delay_q;
        best_metric_d = best_metric_q;
        acc_d         = acc_q;
        settle_cnt_d  = settle_cnt_q;
        sample_cnt_d  = sample_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_SETTLE;
                    delay_d      = '0;
                    busy_d       = 1'b1;
                    settle_cnt_d = '0;
                    sample_cnt_d = '0;
                    acc_d        = '0;
                end
            end
            S_SETTLE: begin
                if (sam_clk_en) begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d      = S_ACCUM;
                        sample_cnt_d = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end
            end
            S_ACCUM: begin
                if (sam_clk_en) begin
                    acc_d = acc_q + {{LOG2_N{product[35]}}, product};
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        state_d = S_COMPARE;
                    end else begin
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end
                end
            end
            S_COMPARE: begin
                // The first candidate always seeds the best; later ones must strictly beat it.
                if (delay_q == '0 || $signed(acc_q) > $signed(best_metric_q)) begin
                    best_metric_d = acc_q;
                    best_delay_d  = delay_q;
                end
                if (delay_q == LAST_DELAY) begin
                    state_d = S_FINISH;
                end else begin
                    state_d      = S_SETTLE;
                    delay_d      = delay_q + 4'd1;
                    acc_d        = '0;
                    settle_cnt_d = '0;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                delay_d = best_delay_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            delay_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            best_delay_q  <= '0;
            best_metric_q <= '0;
            acc_q         <= '0;
            settle_cnt_q  <= '0;
            sample_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            delay_q       <= delay_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            best_delay_q  <= best_delay_d;
            best_metric_q <= best_metric_d;
            acc_q         <= acc_d;
            settle_cnt_q  <= settle_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
        end
    end

    assign delay_change = delay_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign best_delay   = best_delay_q;
    assign best_metric  = best_metric_q;

endmodule

// File: tb/tb_delay_align_ctrl.sv
// Directed bench for delay_align_ctrl: periodic 16-sample source so every correlation
// window sees one full period, making results independent of enable spacing.
module tb_delay_align_ctrl;

    localparam int LOG2_N = 4;
    localparam int W      = 36 + LOG2_N;

    logic          sys_clk = 1'b0;
    logic          reset;
    logic          sam_clk_en;
    logic          start;
    logic [17:0]   ref_sig;
    logic [17:0]   dly_sig;
    logic [3:0]    delay_change;
    logic          busy;
    logic          done;
    logic [3:0]    best_delay;
    logic [W-1:0]  best_metric;

    always #5 sys_clk = ~sys_clk;

    delay_align_ctrl #(
        .MAX_DELAY      (10),
        .SETTLE_SAMPLES (2),
        .LOG2_N         (LOG2_N)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .sam_clk_en   (sam_clk_en),
        .start        (start),
        .ref_sig      (ref_sig),
        .dly_sig      (dly_sig),
        .delay_change (delay_change),
        .busy         (busy),
        .done         (done),
        .best_delay   (best_delay),
        .best_metric  (best_metric)
    );

    int checks = 0;
    int errors = 0;

    logic signed [17:0]  tbl [16];
    int                  en_mode;
    int                  src_sel;
    int                  n_idx;
    int                  cyc;
    int                  done_cnt;
    int                  sweep_ticks;
    int                  en_cnt [16];
    int                  busy_bad;
    logic signed [W-1:0] energy;
    logic signed [W-1:0] sq;
    logic [W-1:0]        metric_ref;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural delay line: ref is the source delayed by 7, dly by delay_change.
    task automatic tick();
        logic       en;
        logic [3:0] ri;
        logic [3:0] di;
        case (en_mode)
            0:       en = (cyc % 4 == 0);
            1:       en = 1'b1;
            default: en = ($urandom_range(0, 2) == 0);
        endcase
        sam_clk_en = en;
        ri = 4'(n_idx - 7);
        di = 4'(n_idx - int'(delay_change));
        case (src_sel)
            0: begin
                ref_sig = tbl[ri];
                dly_sig = tbl[di];
            end
            1: begin
                ref_sig = 18'd0;
                dly_sig = 18'd0;
            end
            default: begin
                ref_sig = 18'h20000;
                dly_sig = 18'h20000;
            end
        endcase
        if (en && busy === 1'b1) en_cnt[delay_change]++;
        @(posedge sys_clk);
        #1;
        if (en) n_idx++;
        cyc++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic sweep(input int mode, input int src, input int restart_at);
        en_mode  = mode;
        src_sel  = src;
        n_idx    = 0;
        done_cnt = 0;
        busy_bad = 0;
        sweep_ticks = 0;
        for (int d = 0; d < 16; d++) en_cnt[d] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 5000 && done !== 1'b1; i++) begin
            if (busy !== 1'b1) busy_bad = 1;
            start = (i == restart_at);
            tick();
            sweep_ticks++;
        end
        start = 1'b0;
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_until_done", 64'(busy_bad), 64'd0);
    endtask

    initial begin
        tbl[0]  =  18'sd12345;  tbl[1]  = -18'sd54321; tbl[2]  =  18'sd98765;  tbl[3]  = -18'sd7777;
        tbl[4]  =  18'sd31415;  tbl[5]  = -18'sd27182; tbl[6]  =  18'sd16180;  tbl[7]  = -18'sd100000;
        tbl[8]  =  18'sd4242;   tbl[9]  =  18'sd77777; tbl[10] = -18'sd65536;  tbl[11] =  18'sd1000;
        tbl[12] = -18'sd12000;  tbl[13] =  18'sd55555; tbl[14] = -18'sd33333;  tbl[15] =  18'sd88888;
        energy = '0;
        for (int k = 0; k < 16; k++) begin
            sq     = W'(tbl[k]);
            energy = energy + sq * sq;
        end

        reset = 1'b1; start = 1'b1; sam_clk_en = 1'b0;
        ref_sig = '0; dly_sig = '0;
        en_mode = 1; src_sel = 1; n_idx = 0; cyc = 0; done_cnt = 0;

        // Reset with start held high
        tick();
        tick();
        chk("rst_delay_change", 64'(delay_change), 64'd0);
        chk("rst_busy",         64'(busy),         64'd0);
        chk("rst_done",         64'(done),         64'd0);
        chk("rst_best_delay",   64'(best_delay),   64'd0);
        chk("rst_best_metric",  64'(best_metric),  64'd0);
        reset = 1'b0; start = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_done_cnt", 64'(done_cnt), 64'd0);

        // Alignment, enable every 4 clocks
        sweep(0, 0, -1);
        chk("a4_best_delay",   64'(best_delay),   64'd7);
        chk("a4_delay_change", 64'(delay_change), 64'd7);
        chk("a4_best_metric",  64'(best_metric),  64'(energy));
        chk("a4_busy_at_done", 64'(busy),         64'd0);
        for (int d = 0; d <= 10; d++) chk($sformatf("a4_enables_d%0d", d), 64'(en_cnt[d]), 64'd18);
        metric_ref = best_metric;
        tick();
        chk("a4_done_one_cycle", 64'(done), 64'd0);
        chk("a4_busy_after",     64'(busy), 64'd0);

        // Enable every cycle
        sweep(1, 0, -1);
        chk("a1_best_delay",  64'(best_delay),  64'd7);
        chk("a1_best_metric", 64'(best_metric), 64'(metric_ref));
        chk("a1_sweep_ticks", 64'(sweep_ticks), 64'd210);
        tick();

        // Random enable gaps
        sweep(2, 0, -1);
        chk("ar_best_delay",   64'(best_delay),   64'd7);
        chk("ar_best_metric",  64'(best_metric),  64'(metric_ref));
        chk("ar_delay_change", 64'(delay_change), 64'd7);
        tick();

        // start pulsed mid-ACCUM must be ignored
        sweep(1, 0, 4);
        chk("rs_sweep_ticks", 64'(sweep_ticks), 64'd210);
        chk("rs_best_delay",  64'(best_delay),  64'd7);
        repeat (30) tick();
        chk("rs_single_done", 64'(done_cnt), 64'd1);
        chk("rs_busy_idle",   64'(busy),     64'd0);

        // Extreme magnitude: all candidates tie at 2^38
        sweep(1, 2, -1);
        chk("ex_best_delay",   64'(best_delay),   64'd0);
        chk("ex_best_metric",  64'(best_metric),  64'd274877906944);
        chk("ex_delay_change", 64'(delay_change), 64'd0);
        tick();

        // Zero input: ties keep delay 0, metric overwritten by first compare
        sweep(0, 1, -1);
        chk("z_best_delay",   64'(best_delay),   64'd0);
        chk("z_best_metric",  64'(best_metric),  64'd0);
        chk("z_delay_change", 64'(delay_change), 64'd0);
        tick();

        // Reset mid-SETTLE at delay 5
        en_mode = 0; src_sel = 0; n_idx = 0; done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3000 && delay_change !== 4'd5; i++) tick();
        chk("ab_reached_d5", 64'(delay_change), 64'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ab_delay_change", 64'(delay_change), 64'd0);
        chk("ab_busy",         64'(busy),         64'd0);
        chk("ab_best_metric",  64'(best_metric),  64'd0);
        repeat (40) tick();
        chk("ab_no_done", 64'(done_cnt), 64'd0);
        chk("ab_idle_busy", 64'(busy), 64'd0);

        // Back in IDLE: a fresh sweep still works
        sweep(1, 0, -1);
        chk("fin_best_delay",  64'(best_delay),  64'd7);
        chk("fin_best_metric", 64'(best_metric), 64'(metric_ref));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_align_ctrl.md
Name: delay_align_ctrl

Overview:
Automatic delay-alignment controller for the programmable sample delay line. On a start request it sweeps the delay line's 4-bit delay select from 0 to MAX_DELAY. At each setting it correlates a reference signal against the delayed signal over a fixed window of samples. It then programs the delay select with the setting that gave the largest correlation, and sits between the test/control logic and the delay line's delay_change input.

Parameters:
MAX_DELAY, 10, highest delay select value swept (1..15).
SETTLE_SAMPLES, 2, sample enables discarded after each delay change before accumulating (1..255).
LOG2_N, 4, log2 of the correlation window length in samples (N = 2^LOG2_N, 1..8).

Ports:
sys_clk  input  1  system clock; every register updates on its rising edge.
reset  input  1  synchronous, active-high reset.
sam_clk_en  input  1  one-cycle sample-rate enable, same as the delay line's.
start  input  1  begin a sweep; sampled only in IDLE.
ref_sig  input  18  signed 1s17 reference signal.
dly_sig  input  18  signed 1s17 delayed signal (the delay line's sig_out).
delay_change  output  4  delay select driven to the delay line (registered).
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when a sweep completes.
best_delay  output  4  winning delay select of the last sweep.
best_metric  output  36+LOG2_N  signed correlation sum of the winning delay.

Behaviour:
- Reset (synchronous, takes priority over all else):
  - Outputs: delay_change=0, busy=0, done=0, best_delay=0, best_metric=0.
  - Internal: state=IDLE; all counters and the accumulator cleared.
- FSM states: IDLE, SETTLE, ACCUM, COMPARE, FINISH.
- IDLE:
  - start=1 moves to SETTLE on the next edge.
  - On that same edge: delay_change=0, busy=1, settle count=0, sample count=0, accumulator=0.
  - start has no effect in any other state.
- SETTLE:
  - Counts sam_clk_en pulses; sys_clk cycles without an enable do not advance the count.
  - On the cycle carrying the SETTLE_SAMPLES-th enable: go to ACCUM with sample count=0.
- ACCUM:
  - On each sam_clk_en: accumulator += ref_sig*dly_sig, using the 36-bit signed product sign-extended to 36+LOG2_N bits.
  - ref_sig and dly_sig are sampled in the same cycle as the enable.
  - No overflow is possible by construction; no saturation logic.
  - After the N-th enable has been accumulated: go to COMPARE.
- COMPARE (exactly one sys_clk):
  - Update best_metric=accumulator and best_delay=delay_change if delay_change==0, or if accumulator > best_metric (signed, strictly greater).
  - Ties keep the lower delay.
  - If delay_change==MAX_DELAY: go to FINISH.
  - Otherwise: delay_change+=1, clear the accumulator and settle count, go to SETTLE.
- FINISH (one sys_clk):
  - delay_change=best_delay, done=1 for this single cycle, busy=0, go to IDLE.
  - done is registered and is high in the cycle after FINISH is entered.
  - best_delay and best_metric hold until the next sweep's first COMPARE or reset.
- Sweep duration: exactly (MAX_DELAY+1)*(SETTLE_SAMPLES+N) sample enables, plus (MAX_DELAY+1)+2 sys_clk of overhead.
- Simultaneous events:
  - start and reset both high: reset wins.
  - sam_clk_en during COMPARE or FINISH is ignored; it does not count toward the next SETTLE.
- Reset mid-sweep: abort immediately to the reset values above; no done pulse.
- delay_change must never exceed MAX_DELAY.

Test Plan:
- Reset value check: assert reset 2 cycles with start=1 -> all outputs 0, busy stays 0, no done pulse.
- Alignment, enable every 4 sys_clk:
  - Stimulus: ref_sig = pseudo-random 18-bit sequence; dly_sig from a behavioural delay-line model driven by delay_change, true offset 7.
  - Expected: best_delay=7, delay_change=7 after done, done high exactly 1 cycle, busy high from the cycle after start to the done cycle.
- Tie / zero input: ref_sig=dly_sig=0 -> best_delay=0, best_metric=0, delay_change=0 at done.
- Extreme magnitude, LOG2_N=4: ref_sig=dly_sig=-131072 constant -> every candidate gives 2^38, best_delay=0, best_metric=274877906944.
- Control robustness:
  - Pulse start again mid-ACCUM -> ignored; exactly one done per sweep.
  - Assert reset mid-SETTLE at delay_change=5 -> next cycle delay_change=0, busy=0, state IDLE.
- Enable gating: repeat the offset-7 case with sam_clk_en every cycle and with random gaps -> identical best_delay and best_metric.
  - Check enables consumed per candidate = SETTLE_SAMPLES+N = 18.
